// File: rtl/ascon_round_seq.sv
// ---------------------------------------------------------------------------
// ascon_round_seq
//
// Iterative round sequencer for the ASCON permutation. The 320-bit state
// {x0,x1,x2,x3,x4} (x0 in the most significant word) lives in a register.
// The register loops through an external combinational round datapath
// (constant addition -> substitution -> linear diffusion) once per clock.
// The sequencer supplies the round index for the constant-addition stage. It
// runs either pa (ROUNDS_A rounds) or pb (ROUNDS_B rounds). Both always finish
// on round index 11.
//
// Ports:
//   clock_i        in   1    system clock, rising edge
//   reset_i        in   1    asynchronous reset, active-high
//   start_i        in   1    request a run (ignored while busy)
//   mode_pb_i      in   1    0 = pa, 1 = pb; sampled with start_i
//   state_i        in   320  initial state, loaded on an accepted start
//   round_state_i  in   320  round datapath output for (state_o, round_o)
//   state_o        out  320  registered state / permutation result
//   round_o        out  4    current round index
//   busy_o         out  1    high while rounds are being applied
//   done_o         out  1    one-cycle pulse after the final round is written
// ---------------------------------------------------------------------------
module ascon_round_seq #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         mode_pb_i,
    input  logic [319:0] state_i,
    input  logic [319:0] round_state_i,
    output logic [319:0] state_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // Both permutations end on round 11, so a shorter run simply starts later.
    localparam logic [3:0] FIRST_A    = 4'(12 - ROUNDS_A);
    localparam logic [3:0] FIRST_B    = 4'(12 - ROUNDS_B);
    localparam logic [3:0] LAST_ROUND = 4'd11;

    fsm_t         fsm_q,   fsm_d;
    logic [319:0] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                // A start in the done cycle is accepted here. Clearing done_d
                // by default drops the pulse as the next run loads.
                if (start_i) begin
                    state_d = state_i;
                    round_d = mode_pb_i ? FIRST_B : FIRST_A;
                    busy_d  = 1'b1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_state_i;
                if (round_q == LAST_ROUND) begin
                    // round_o parks at 11. It never wraps inside a run.
                    fsm_d  = IDLE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign round_o = round_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_round_seq.sv
// ---------------------------------------------------------------------------
// tb_ascon_round_seq
//
// Bench for ascon_round_seq. A simplified round datapath XORs the round
// constant into x2 only. The expected permutation results come from a
// reference function that folds the constants of the executed rounds into x2.
// ---------------------------------------------------------------------------
module tb_ascon_round_seq;

    localparam int RA = 12;
    localparam int RB = 6;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic         mode_pb_i;
    logic [319:0] state_i;
    logic [319:0] round_state_i;
    logic [319:0] state_o;
    logic [3:0]   round_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    ascon_round_seq #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .mode_pb_i     (mode_pb_i),
        .state_i       (state_i),
        .round_state_i (round_state_i),
        .state_o       (state_o),
        .round_o       (round_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clock_i = ~clock_i;

    // ASCON round constant: high nibble counts down from f, low nibble counts up.
    function automatic logic [7:0] rc(input int r);
        return 8'(((15 - r) << 4) | r);
    endfunction

    // Stand-in round datapath: x2 ^= constant(round_o).
    always_comb begin
        round_state_i = state_o;
        round_state_i[191:128] = state_o[191:128] ^ {56'h0, rc(int'(round_o))};
    end

    // Expected result of an n-round permutation under the stand-in datapath.
    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nrounds);
        logic [319:0] t;
        t = s;
        for (int r = 12 - nrounds; r < 12; r++)
            t[191:128] = t[191:128] ^ {56'h0, rc(r)};
        return t;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic test_reset();
        reset_i = 1'b1; start_i = 1'b0; mode_pb_i = 1'b0; state_i = rand320();
        #2;
        checks++;
        if (state_o !== '0 || round_o !== 4'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: state=%h round=%0d busy=%b done=%b, required all zero",
                     state_o, round_o, busy_o, done_o);
        end
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock_i);
            checks++;
            if (state_o !== '0 || round_o !== 4'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold c%0d: state=%h round=%0d busy=%b done=%b, required all zero",
                         c, state_o, round_o, busy_o, done_o);
            end
        end
    endtask

    // One run from IDLE. If ignore_at > 0, a start with a different mode and
    // state is pulsed at that cycle of the run. It must be ignored.
    task automatic test_single_run(input logic mode, input logic [319:0] init,
                                   input string tag, input int ignore_at);
        int nr;
        logic [319:0] exp;
        nr  = mode ? RB : RA;
        exp = ref_perm(init, nr);
        @(negedge clock_i);
        state_i = init; mode_pb_i = mode; start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0; state_i = rand320();
        for (int n = 1; n <= nr; n++) begin
            checks++;
            if (busy_o !== 1'b1 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_ctrl n%0d: busy=%b done=%b, required busy=1 done=0",
                         tag, n, busy_o, done_o);
            end
            checks++;
            if (round_o !== 4'(12 - nr + n - 1)) begin
                errors++;
                $display("FAIL %s_round n%0d: round=%0d, required %0d", tag, n, round_o, 12 - nr + n - 1);
            end
            if (n == ignore_at) begin
                start_i = 1'b1; mode_pb_i = ~mode; state_i = rand320();
            end
            @(negedge clock_i);
            start_i = 1'b0;
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || round_o !== 4'd11) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b round=%0d, required done=1 busy=0 round=11",
                     tag, done_o, busy_o, round_o);
        end
        checks++;
        if (state_o !== exp) begin
            errors++;
            $display("FAIL %s_result: state=%h, required %h", tag, state_o, exp);
        end
        @(negedge clock_i);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || round_o !== 4'd11 || state_o !== exp) begin
            errors++;
            $display("FAIL %s_after: done=%b busy=%b round=%0d state=%h, required 0 0 11 %h",
                     tag, done_o, busy_o, round_o, state_o, exp);
        end
    endtask

    task automatic test_abort();
        @(negedge clock_i);
        state_i = rand320(); mode_pb_i = 1'b0; start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        for (int n = 1; n < 6; n++) @(negedge clock_i);
        checks++;
        if (round_o !== 4'd5 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: round=%0d busy=%b, required round=5 busy=1", round_o, busy_o);
        end
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if (state_o !== '0 || round_o !== 4'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_zero: state=%h round=%0d busy=%b done=%b, required all zero",
                     state_o, round_o, busy_o, done_o);
        end
        @(negedge clock_i);
        reset_i = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock_i);
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet c%0d: done=%b busy=%b, required 0 0", c, done_o, busy_o);
            end
        end
    endtask

    // pb run then pa run with start held high. The second run loads in the
    // done cycle of the first.
    task automatic test_back_to_back();
        logic [319:0] a, b, exp_a, exp_b;
        logic         exp_done;
        int           exp_round;
        a = rand320(); b = rand320();
        exp_a = ref_perm(a, RB);
        exp_b = ref_perm(b, RA);
        @(negedge clock_i);
        state_i = a; mode_pb_i = 1'b1; start_i = 1'b1;
        @(negedge clock_i);
        state_i = b; mode_pb_i = 1'b0;
        for (int n = 1; n <= RB + 1 + RA + 1; n++) begin
            exp_done  = (n == RB + 1) || (n == RB + 1 + RA + 1);
            exp_round = exp_done ? 11 : (n <= RB ? 12 - RB + n - 1 : n - RB - 2);
            checks++;
            if (done_o !== exp_done || busy_o !== !exp_done) begin
                errors++;
                $display("FAIL b2b_ctrl n%0d: done=%b busy=%b, required done=%b busy=%b",
                         n, done_o, busy_o, exp_done, !exp_done);
            end
            checks++;
            if (round_o !== 4'(exp_round)) begin
                errors++;
                $display("FAIL b2b_round n%0d: round=%0d, required %0d", n, round_o, exp_round);
            end
            if (n == RB + 1) begin
                checks++;
                if (state_o !== exp_a) begin
                    errors++;
                    $display("FAIL b2b_result_a: state=%h, required %h", state_o, exp_a);
                end
            end
            if (n == RB + 1 + RA + 1) begin
                checks++;
                if (state_o !== exp_b) begin
                    errors++;
                    $display("FAIL b2b_result_b: state=%h, required %h", state_o, exp_b);
                end
                start_i = 1'b0;
            end
            @(negedge clock_i);
        end
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || state_o !== exp_b) begin
            errors++;
            $display("FAIL b2b_end: done=%b busy=%b state=%h, required 0 0 %h",
                     done_o, busy_o, state_o, exp_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_run(1'b0, {64'h80400c0600000000, 256'h0}, "pa", -1);
        test_single_run(1'b1, {64'h80400c0600000000, 256'h0}, "pb", -1);
        test_single_run(1'b0, rand320(), "pa_ignore", 4);
        test_abort();
        test_single_run(1'b1, rand320(), "post_abort", -1);
        test_back_to_back();
        for (int i = 0; i < 4; i++)
            test_single_run(1'($urandom_range(0, 1)), rand320(), "rnd", -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
